// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants used by the SubBytes datapath
// and the key expansion logic.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int NB     = 4;
    localparam int NBYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_t;

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a purely combinational lookup.
// Shared between the folded SubBytes stage and key expansion.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] result
);

    always_comb begin
        result = 8'h00;
        case (data)
            8'h00: result = 8'h63;  8'h01: result = 8'h7c;  8'h02: result = 8'h77;  8'h03: result = 8'h7b;
            8'h04: result = 8'hf2;  8'h05: result = 8'h6b;  8'h06: result = 8'h6f;  8'h07: result = 8'hc5;
            8'h08: result = 8'h30;  8'h09: result = 8'h01;  8'h0a: result = 8'h67;  8'h0b: result = 8'h2b;
            8'h0c: result = 8'hfe;  8'h0d: result = 8'hd7;  8'h0e: result = 8'hab;  8'h0f: result = 8'h76;
            8'h10: result = 8'hca;  8'h11: result = 8'h82;  8'h12: result = 8'hc9;  8'h13: result = 8'h7d;
            8'h14: result = 8'hfa;  8'h15: result = 8'h59;  8'h16: result = 8'h47;  8'h17: result = 8'hf0;
            8'h18: result = 8'had;  8'h19: result = 8'hd4;  8'h1a: result = 8'ha2;  8'h1b: result = 8'haf;
            8'h1c: result = 8'h9c;  8'h1d: result = 8'ha4;  8'h1e: result = 8'h72;  8'h1f: result = 8'hc0;
            8'h20: result = 8'hb7;  8'h21: result = 8'hfd;  8'h22: result = 8'h93;  8'h23: result = 8'h26;
            8'h24: result = 8'h36;  8'h25: result = 8'h3f;  8'h26: result = 8'hf7;  8'h27: result = 8'hcc;
            8'h28: result = 8'h34;  8'h29: result = 8'ha5;  8'h2a: result = 8'he5;  8'h2b: result = 8'hf1;
            8'h2c: result = 8'h71;  8'h2d: result = 8'hd8;  8'h2e: result = 8'h31;  8'h2f: result = 8'h15;
            8'h30: result = 8'h04;  8'h31: result = 8'hc7;  8'h32: result = 8'h23;  8'h33: result = 8'hc3;
            8'h34: result = 8'h18;  8'h35: result = 8'h96;  8'h36: result = 8'h05;  8'h37: result = 8'h9a;
            8'h38: result = 8'h07;  8'h39: result = 8'h12;  8'h3a: result = 8'h80;  8'h3b: result = 8'he2;
            8'h3c: result = 8'heb;  8'h3d: result = 8'h27;  8'h3e: result = 8'hb2;  8'h3f: result = 8'h75;
            8'h40: result = 8'h09;  8'h41: result = 8'h83;  8'h42: result = 8'h2c;  8'h43: result = 8'h1a;
            8'h44: result = 8'h1b;  8'h45: result = 8'h6e;  8'h46: result = 8'h5a;  8'h47: result = 8'ha0;
            8'h48: result = 8'h52;  8'h49: result = 8'h3b;  8'h4a: result = 8'hd6;  8'h4b: result = 8'hb3;
            8'h4c: result = 8'h29;  8'h4d: result = 8'he3;  8'h4e: result = 8'h2f;  8'h4f: result = 8'h84;
            8'h50: result = 8'h53;  8'h51: result = 8'hd1;  8'h52: result = 8'h00;  8'h53: result = 8'hed;
            8'h54: result = 8'h20;  8'h55: result = 8'hfc;  8'h56: result = 8'hb1;  8'h57: result = 8'h5b;
            8'h58: result = 8'h6a;  8'h59: result = 8'hcb;  8'h5a: result = 8'hbe;  8'h5b: result = 8'h39;
            8'h5c: result = 8'h4a;  8'h5d: result = 8'h4c;  8'h5e: result = 8'h58;  8'h5f: result = 8'hcf;
            8'h60: result = 8'hd0;  8'h61: result = 8'hef;  8'h62: result = 8'haa;  8'h63: result = 8'hfb;
            8'h64: result = 8'h43;  8'h65: result = 8'h4d;  8'h66: result = 8'h33;  8'h67: result = 8'h85;
            8'h68: result = 8'h45;  8'h69: result = 8'hf9;  8'h6a: result = 8'h02;  8'h6b: result = 8'h7f;
            8'h6c: result = 8'h50;  8'h6d: result = 8'h3c;  8'h6e: result = 8'h9f;  8'h6f: result = 8'ha8;
            8'h70: result = 8'h51;  8'h71: result = 8'ha3;  8'h72: result = 8'h40;  8'h73: result = 8'h8f;
            8'h74: result = 8'h92;  8'h75: result = 8'h9d;  8'h76: result = 8'h38;  8'h77: result = 8'hf5;
            8'h78: result = 8'hbc;  8'h79: result = 8'hb6;  8'h7a: result = 8'hda;  8'h7b: result = 8'h21;
            8'h7c: result = 8'h10;  8'h7d: result = 8'hff;  8'h7e: result = 8'hf3;  8'h7f: result = 8'hd2;
            8'h80: result = 8'hcd;  8'h81: result = 8'h0c;  8'h82: result = 8'h13;  8'h83: result = 8'hec;
            8'h84: result = 8'h5f;  8'h85: result = 8'h97;  8'h86: result = 8'h44;  8'h87: result = 8'h17;
            8'h88: result = 8'hc4;  8'h89: result = 8'ha7;  8'h8a: result = 8'h7e;  8'h8b: result = 8'h3d;
            8'h8c: result = 8'h64;  8'h8d: result = 8'h5d;  8'h8e: result = 8'h19;  8'h8f: result = 8'h73;
            8'h90: result = 8'h60;  8'h91: result = 8'h81;  8'h92: result = 8'h4f;  8'h93: result = 8'hdc;
            8'h94: result = 8'h22;  8'h95: result = 8'h2a;  8'h96: result = 8'h90;  8'h97: result = 8'h88;
            8'h98: result = 8'h46;  8'h99: result = 8'hee;  8'h9a: result = 8'hb8;  8'h9b: result = 8'h14;
            8'h9c: result = 8'hde;  8'h9d: result = 8'h5e;  8'h9e: result = 8'h0b;  8'h9f: result = 8'hdb;
            8'ha0: result = 8'he0;  8'ha1: result = 8'h32;  8'ha2: result = 8'h3a;  8'ha3: result = 8'h0a;
            8'ha4: result = 8'h49;  8'ha5: result = 8'h06;  8'ha6: result = 8'h24;  8'ha7: result = 8'h5c;
            8'ha8: result = 8'hc2;  8'ha9: result = 8'hd3;  8'haa: result = 8'hac;  8'hab: result = 8'h62;
            8'hac: result = 8'h91;  8'had: result = 8'h95;  8'hae: result = 8'he4;  8'haf: result = 8'h79;
            8'hb0: result = 8'he7;  8'hb1: result = 8'hc8;  8'hb2: result = 8'h37;  8'hb3: result = 8'h6d;
            8'hb4: result = 8'h8d;  8'hb5: result = 8'hd5;  8'hb6: result = 8'h4e;  8'hb7: result = 8'ha9;
            8'hb8: result = 8'h6c;  8'hb9: result = 8'h56;  8'hba: result = 8'hf4;  8'hbb: result = 8'hea;
            8'hbc: result = 8'h65;  8'hbd: result = 8'h7a;  8'hbe: result = 8'hae;  8'hbf: result = 8'h08;
            8'hc0: result = 8'hba;  8'hc1: result = 8'h78;  8'hc2: result = 8'h25;  8'hc3: result = 8'h2e;
            8'hc4: result = 8'h1c;  8'hc5: result = 8'ha6;  8'hc6: result = 8'hb4;  8'hc7: result = 8'hc6;
            8'hc8: result = 8'he8;  8'hc9: result = 8'hdd;  8'hca: result = 8'h74;  8'hcb: result = 8'h1f;
            8'hcc: result = 8'h4b;  8'hcd: result = 8'hbd;  8'hce: result = 8'h8b;  8'hcf: result = 8'h8a;
            8'hd0: result = 8'h70;  8'hd1: result = 8'h3e;  8'hd2: result = 8'hb5;  8'hd3: result = 8'h66;
            8'hd4: result = 8'h48;  8'hd5: result = 8'h03;  8'hd6: result = 8'hf6;  8'hd7: result = 8'h0e;
            8'hd8: result = 8'h61;  8'hd9: result = 8'h35;  8'hda: result = 8'h57;  8'hdb: result = 8'hb9;
            8'hdc: result = 8'h86;  8'hdd: result = 8'hc1;  8'hde: result = 8'h1d;  8'hdf: result = 8'h9e;
            8'he0: result = 8'he1;  8'he1: result = 8'hf8;  8'he2: result = 8'h98;  8'he3: result = 8'h11;
            8'he4: result = 8'h69;  8'he5: result = 8'hd9;  8'he6: result = 8'h8e;  8'he7: result = 8'h94;
            8'he8: result = 8'h9b;  8'he9: result = 8'h1e;  8'hea: result = 8'h87;  8'heb: result = 8'he9;
            8'hec: result = 8'hce;  8'hed: result = 8'h55;  8'hee: result = 8'h28;  8'hef: result = 8'hdf;
            8'hf0: result = 8'h8c;  8'hf1: result = 8'ha1;  8'hf2: result = 8'h89;  8'hf3: result = 8'h0d;
            8'hf4: result = 8'hbf;  8'hf5: result = 8'he6;  8'hf6: result = 8'h42;  8'hf7: result = 8'h68;
            8'hf8: result = 8'h41;  8'hf9: result = 8'h99;  8'hfa: result = 8'h2d;  8'hfb: result = 8'h0f;
            8'hfc: result = 8'hb0;  8'hfd: result = 8'h54;  8'hfe: result = 8'hbb;  8'hff: result = 8'h16;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Folded AES-128 SubBytes: substitutes one 4-byte column per cycle through
// four shared S-boxes, with valid/ready on both sides for stalling.
module sub_bytes_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    sb_state_t   state_q;
    sb_state_t   state_d;
    logic [1:0]  col_q;
    state_t      src_q;
    state_t      res_q;
    logic [31:0] src_col;
    logic [31:0] sub_col;

    assign src_col = src_q[{col_q, 5'd0} +: 32];

    for (genvar b = 0; b < NB; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data   (src_col[b*8 +: 8]),
            .result (sub_col[b*8 +: 8])
        );
    end

    // Handshake outputs decode the state register only, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the active column of res is written; the rest holds until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                src_q <= in_state;
                col_q <= 2'd0;
            end
            if (state_q == BUSY) begin
                res_q[{col_q, 5'd0} +: 32] <= sub_col;
                col_q                      <= col_q + 2'd1;
            end
        end
    end

    assign out_state = res_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: table of known-answer vectors plus
// backpressure, reset-abort and back-to-back sequences.
module tb_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [127:0] in_state;
        logic [127:0] exp_state;
    } vec_t;

    vec_t vecs[3];

    sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Literals below are written byte 0 first; the port packs byte 0 at the LSB.
    function automatic logic [127:0] bytes_first(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = v[(15-i)*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Reference S-box from first principles: GF(2^8) inverse then affine map.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        if (x != 8'h00)
            for (int i = 1; i < 256; i++)
                if (gf_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] sub_state_model(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_model(v[i*8 +: 8]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    endtask

    // Offers one block while idle and waits (bounded) for out_valid.
    task automatic apply_stimulus(input string name, input logic [127:0] s);
        int cycles;
        check_output({name, " in_ready before"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = s;
        tick();
        in_valid = 1'b0;
        in_state = '0;
        cycles   = 0;
        while (!out_valid && cycles < 16) begin
            tick();
            cycles++;
        end
        check_output({name, " latency"}, 128'(cycles), 128'd4);
    endtask

    task automatic complete_transfer(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output({name, " idle after out"}, 128'({in_ready, out_valid, busy}), 128'b100);
    endtask

    logic [127:0] held;
    logic [127:0] blk[3];
    int           acc_cyc[3];
    int           k_in;
    int           k_out;

    initial begin
        vecs[0].in_state  = '0;
        vecs[0].exp_state = {16{8'h63}};
        vecs[1].in_state  = bytes_first(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        vecs[1].exp_state = bytes_first(128'hd42711aee0bf98f1b8b45de51e415230);
        vecs[2].in_state  = bytes_first(128'h000102030405060708090a0b0c0d0e0f);
        vecs[2].exp_state = bytes_first(128'h637c777bf26b6fc53001672bfed7ab76);

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_output("reset in_ready",  128'(in_ready),  128'd1);
        check_output("reset out_valid", 128'(out_valid), 128'd0);
        check_output("reset busy",      128'(busy),      128'd0);
        check_output("reset out_state", out_state,       128'd0);

        for (int v = 0; v < 3; v++) begin
            apply_stimulus($sformatf("vec%0d", v), vecs[v].in_state);
            check_output($sformatf("vec%0d out_state", v), out_state, vecs[v].exp_state);
            complete_transfer($sformatf("vec%0d", v));
        end

        // Backpressure: DONE must hold and ignore new offers.
        apply_stimulus("bp", vecs[1].in_state);
        held     = out_state;
        in_valid = 1'b1;
        in_state = {16{8'h5a}};
        for (int c = 0; c < 10; c++) begin
            tick();
            check_output("bp out_state stable", out_state, held);
            check_output("bp ctrl", 128'({in_ready, out_valid}), 128'b01);
        end
        in_valid = 1'b0;
        check_output("bp result", out_state, vecs[1].exp_state);
        complete_transfer("bp");

        // Reset two columns into a block, then a clean 0xff block.
        in_valid = 1'b1;
        in_state = vecs[1].in_state;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check_output("abort busy before reset", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort ctrl", 128'({in_ready, out_valid, busy}), 128'b100);
        check_output("abort out_state", out_state, 128'd0);

        rst = 1'b1; in_valid = 1'b1; in_state = {16{8'h11}};
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_output("rst with in_valid", 128'({in_ready, busy}), 128'b10);

        apply_stimulus("ff", {16{8'hff}});
        check_output("ff out_state", out_state, {16{8'h16}});
        complete_transfer("ff");

        // Back-to-back with both handshakes held high.
        for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        k_in = 0; k_out = 0;
        in_valid = 1'b1; out_ready = 1'b1; in_state = blk[0];
        for (int cyc = 0; cyc < 60 && k_out < 3; cyc++) begin
            if (out_valid && out_ready) begin
                check_output($sformatf("b2b blk%0d", k_out), out_state, sub_state_model(blk[k_out]));
                k_out++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[k_in] = cyc;
                k_in++;
            end
            tick();
            if (k_in < 3) in_state = blk[k_in];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_output("b2b blocks out", 128'(k_out), 128'd3);
        if (k_in == 3) begin
            check_output("b2b spacing 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
            check_output("b2b spacing 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
        end else begin
            check_output("b2b accepts", 128'(k_in), 128'd3);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
